// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request handshake for the ALU (req0) and load path (req1)
interface regfile_wb_arbiter_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_rd, req1_rd;
  logic [63:0] req0_data, req1_data;
  modport master (output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
                  input req0_ready, req1_ready);
  modport slave (input req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
                 output req0_ready, req1_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester RegisterFile write-port arbiter with busy scoreboard.
// Define REGARB_FIXED_PRI_EN for fixed priority to requester 1 instead of round-robin.
module regfile_wb_arbiter (
  input  logic                       Clk,
  input  logic                       Reset,
  regfile_wb_arbiter_if.slave        req,
  input  logic                       alloc_valid,
  input  logic [4:0]                 alloc_rd,
  input  logic [4:0]                 RA,
  input  logic [4:0]                 RB,
  output logic                       hazA,
  output logic                       hazB,
  output logic [31:0]                busy,
  output logic                       RegWr,
  output logic [4:0]                 RW,
  output logic [63:0]                BusW
);
  logic        z0, z1, e0, e1, g0, g1, grant;
  logic [4:0]  wrd;
  logic [63:0] wdata;
  logic [31:0] busy_n;
  always_comb begin
    z0 = req.req0_valid && req.req0_rd == 5'd31;
    z1 = req.req1_valid && req.req1_rd == 5'd31;
    e0 = req.req0_valid && req.req0_rd != 5'd31;
    e1 = req.req1_valid && req.req1_rd != 5'd31;
  end
`ifdef REGARB_FIXED_PRI_EN
  assign g1 = e1;
  assign g0 = e0 && !e1;
`else
  // last = 1 favours requester 0; it always records the most recent winner
  logic last;
  assign g0 = e0 && (!e1 || last);
  assign g1 = e1 && (!e0 || !last);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) last <= 1'b1;
    else if (g0 || g1) last <= g1;
`endif
  assign grant         = g0 || g1;
  assign wrd           = g1 ? req.req1_rd : req.req0_rd;
  assign wdata         = g1 ? req.req1_data : req.req0_data;
  assign req.req0_ready = !Reset && (z0 || g0);
  assign req.req1_ready = !Reset && (z1 || g1);
  // set after clear so a same-edge re-allocation keeps the register busy
  always_comb begin
    busy_n = grant ? busy & ~(32'd1 << wrd) : busy;
    busy_n = (alloc_valid && alloc_rd != 5'd31) ? busy_n | (32'd1 << alloc_rd) : busy_n;
    busy_n[31] = 1'b0;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      RegWr <= 1'b0;
      RW    <= '0;
      BusW  <= '0;
      busy  <= '0;
    end else begin
      RegWr <= grant;
      busy  <= busy_n;
      if (grant) begin
        RW   <= wrd;
        BusW <= wdata;
      end
    end
  assign hazA = busy[RA];
  assign hazB = busy[RB];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, XZR retirement, scoreboard and reset
module tb_regfile_wb_arbiter;
`ifdef REGARB_FIXED_PRI_EN
  localparam bit fx = 1'b1;
`else
  localparam bit fx = 1'b0;
`endif
  logic        Clk = 0, Reset = 1;
  logic        alloc_valid = 0;
  logic [4:0]  alloc_rd = 0, RA = 0, RB = 0;
  logic        hazA, hazB, RegWr;
  logic [31:0] busy;
  logic [4:0]  RW;
  logic [63:0] BusW, BusA;
  logic [63:0] rf [32];
  int checks = 0, errors = 0;
  regfile_wb_arbiter_if bus ();
  regfile_wb_arbiter dut (.Clk(Clk), .Reset(Reset), .req(bus), .alloc_valid(alloc_valid),
    .alloc_rd(alloc_rd), .RA(RA), .RB(RB), .hazA(hazA), .hazB(hazB), .busy(busy),
    .RegWr(RegWr), .RW(RW), .BusW(BusW));
  always #5 Clk = ~Clk;
  // behavioural RegisterFile: latches the write port on the negedge
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(negedge Clk) if (RegWr) rf[RW] <= BusW;
  assign BusA = rf[RA];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    alloc_valid = 0;
  endtask

  task automatic do_reset;
    idle();
    Reset = 1;
    tick();
    Reset = 0;
    tick();
  endtask

  task automatic test_reset;
    bus.req0_valid = 1; bus.req0_rd = 5'd3; bus.req0_data = 64'h33;
    bus.req1_valid = 1; bus.req1_rd = 5'd4; bus.req1_data = 64'h44;
    tick();
    checks++; if (RegWr !== 1'b0 || RW !== 5'd0 || BusW !== 64'd0) begin errors++;
      $display("FAIL reset_port got RegWr=%0d RW=%0d BusW=%h want 0 0 0", RegWr, RW, BusW); end
    checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
    checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin errors++;
      $display("FAIL reset_ready got %0d%0d want 00", bus.req0_ready, bus.req1_ready); end
    bus.req0_rd = 5'd31;
    #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++;
      $display("FAIL reset_xzr_ready got %0d want 0", bus.req0_ready); end
    idle();
    Reset = 0;
    tick();
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL post_reset_regwr got %0d want 0", RegWr); end
  endtask

  task automatic test_lone_write;
    bus.req0_valid = 1; bus.req0_rd = 5'd5; bus.req0_data = 64'h1234;
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL lone_ready got %0d want 1", bus.req0_ready); end
    tick();
    idle();
    checks++; if (RegWr !== 1'b1 || RW !== 5'd5 || BusW !== 64'h1234) begin errors++;
      $display("FAIL lone_port got RegWr=%0d RW=%0d BusW=%h want 1 5 1234", RegWr, RW, BusW); end
    RA = 5'd5;
    @(negedge Clk); #1;
    checks++; if (BusA !== 64'h1234) begin errors++; $display("FAIL lone_busa got %h want 1234", BusA); end
    tick();
    checks++; if (RegWr !== 1'b0 || RW !== 5'd5) begin errors++;
      $display("FAIL lone_hold got RegWr=%0d RW=%0d want 0 5", RegWr, RW); end
  endtask

  task automatic test_contention;
    logic w;
    do_reset();
    bus.req0_valid = 1; bus.req0_rd = 5'd10; bus.req0_data = 64'h1010;
    bus.req1_valid = 1; bus.req1_rd = 5'd11; bus.req1_data = 64'h103000;
    for (int i = 0; i < 6; i++) begin
      w = fx ? 1'b1 : i[0];
      #1;
      checks++; if (bus.req0_ready !== !w || bus.req1_ready !== w) begin errors++;
        $display("FAIL contend_ready[%0d] got %0d%0d want %0d%0d", i, bus.req0_ready, bus.req1_ready, !w, w); end
      tick();
      checks++; if (RegWr !== 1'b1 || RW !== (w ? 5'd11 : 5'd10) || BusW !== (w ? 64'h103000 : 64'h1010)) begin errors++;
        $display("FAIL contend_port[%0d] got RegWr=%0d RW=%0d BusW=%h want winner %0d", i, RegWr, RW, BusW, w); end
    end
    idle();
    tick();
  endtask

  task automatic test_xzr;
    bus.req0_valid = 1; bus.req0_rd = 5'd31; bus.req0_data = 64'h12345678;
    bus.req1_valid = 1; bus.req1_rd = 5'd2;  bus.req1_data = 64'h22;
    #1;
    checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin errors++;
      $display("FAIL xzr_ready got %0d%0d want 11", bus.req0_ready, bus.req1_ready); end
    tick();
    idle();
    checks++; if (RegWr !== 1'b1 || RW !== 5'd2 || BusW !== 64'h22) begin errors++;
      $display("FAIL xzr_port got RegWr=%0d RW=%0d BusW=%h want 1 2 22", RegWr, RW, BusW); end
    bus.req0_valid = 1;
    tick();
    idle();
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL xzr_only_regwr got %0d want 0", RegWr); end
    RA = 5'd31;
    @(negedge Clk); #1;
    checks++; if (BusA !== 64'd0) begin errors++; $display("FAIL xzr_busa got %h want 0", BusA); end
    tick();
    // req1 won last, the XZR retirement must not disturb the pointer
    bus.req0_valid = 1; bus.req0_rd = 5'd6; bus.req0_data = 64'h66;
    bus.req1_valid = 1; bus.req1_rd = 5'd7; bus.req1_data = 64'h77;
    #1;
    checks++; if (bus.req0_ready !== !fx || bus.req1_ready !== fx) begin errors++;
      $display("FAIL xzr_pointer got %0d%0d want %0d%0d", bus.req0_ready, bus.req1_ready, !fx, fx); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_scoreboard;
    alloc_valid = 1; alloc_rd = 5'd13;
    tick();
    alloc_valid = 0;
    RA = 5'd13; RB = 5'd12;
    #1;
    checks++; if (busy !== 32'h2000) begin errors++; $display("FAIL sb_alloc got %h want 00002000", busy); end
    checks++; if (hazA !== 1'b1 || hazB !== 1'b0) begin errors++;
      $display("FAIL sb_haz got %0d%0d want 10", hazA, hazB); end
    bus.req1_valid = 1; bus.req1_rd = 5'd13; bus.req1_data = 64'hABCD;
    tick();
    idle();
    checks++; if (busy !== 32'd0 || RW !== 5'd13 || BusW !== 64'hABCD) begin errors++;
      $display("FAIL sb_clear got busy=%h RW=%0d BusW=%h want 0 13 abcd", busy, RW, BusW); end
    alloc_valid = 1;
    tick();
    bus.req1_valid = 1;
    tick();
    idle();
    checks++; if (busy !== 32'h2000) begin errors++; $display("FAIL sb_realloc got %h want 00002000", busy); end
    alloc_valid = 1; alloc_rd = 5'd31; RB = 5'd31;
    tick();
    alloc_valid = 0;
    checks++; if (busy !== 32'h2000 || hazB !== 1'b0) begin errors++;
      $display("FAIL sb_xzr got busy=%h hazB=%0d want 00002000 0", busy, hazB); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    alloc_valid = 1; alloc_rd = 5'd4;
    tick();
    alloc_valid = 0;
    bus.req0_valid = 1; bus.req0_rd = 5'd8; bus.req0_data = 64'h88;
    bus.req1_valid = 1; bus.req1_rd = 5'd4; bus.req1_data = 64'h44;
    #1;
    checks++; if (bus.req1_ready !== fx) begin errors++; $display("FAIL mid_wait got %0d want %0d", bus.req1_ready, fx); end
    tick();
    Reset = 1;
    #1;
    checks++; if (RegWr !== 1'b0 || busy !== 32'd0 || bus.req1_ready !== 1'b0) begin errors++;
      $display("FAIL mid_reset got RegWr=%0d busy=%h ready1=%0d want 0 0 0", RegWr, busy, bus.req1_ready); end
    idle();
    tick();
    Reset = 0;
    tick();
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL mid_drop got %0d want 0", RegWr); end
    bus.req1_valid = 1;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL mid_retry_ready got %0d want 1", bus.req1_ready); end
    tick();
    idle();
    checks++; if (RegWr !== 1'b1 || RW !== 5'd4 || BusW !== 64'h44) begin errors++;
      $display("FAIL mid_retry_port got RegWr=%0d RW=%0d BusW=%h want 1 4 44", RegWr, RW, BusW); end
    RA = 5'd4;
    @(negedge Clk); #1;
    checks++; if (BusA !== 64'h44) begin errors++; $display("FAIL mid_busa got %h want 44", BusA); end
  endtask

  initial begin
    bus.req0_rd = 0; bus.req0_data = 0; bus.req1_rd = 0; bus.req1_data = 0;
    idle();
    test_reset();
    test_lone_write();
    test_contention();
    test_xzr();
    test_scoreboard();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
